// File: rtl/mem_port_arbiter.sv
// Arbiter for the shared instruction/data memory port: the MEM stage has priority,
// and an anti-starvation counter forces an IF grant after MAX_WAIT consecutive losses.
module mem_port_arbiter #(
    parameter int LAT      = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic if_req_i,
    input  logic mem_req_i,
    input  logic mem_we_i,
    output logic sel_o,
    output logic mem_en_o,
    output logic mem_we_o,
    output logic if_gnt_o,
    output logic mem_gnt_o,
    output logic if_done_o,
    output logic mem_done_o,
    output logic busy_o,
    output logic dbg_state_o
);

    // Handshake: a requester raises req and holds it until its one-cycle done pulse.
    // Requests are sampled only in IDLE, and a granted access always runs to completion.

    localparam int LCW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int WCW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [LCW-1:0] LAT_LOAD = LCW'(LAT - 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t           state, state_nxt;
    logic             owner, owner_nxt;
    logic             we_lat, we_lat_nxt;
    logic [LCW-1:0]   lat_cnt, lat_nxt;
    logic [WCW-1:0]   wait_cnt, wait_nxt;
    logic             grant_mem;
    logic             force_if;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            owner    <= 1'b0;
            we_lat   <= 1'b0;
            lat_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            we_lat   <= we_lat_nxt;
            lat_cnt  <= lat_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        we_lat_nxt = we_lat;
        lat_nxt    = lat_cnt;
        wait_nxt   = wait_cnt;
        force_if   = (MAX_WAIT != 0) && (wait_cnt == WAIT_MAX);
        grant_mem  = 1'b0;
        case (state)
            IDLE: begin
                if (if_req_i || mem_req_i) begin
                    grant_mem  = mem_req_i && !(if_req_i && force_if);
                    state_nxt  = BUSY;
                    lat_nxt    = LAT_LOAD;
                    owner_nxt  = grant_mem;
                    we_lat_nxt = grant_mem && mem_we_i;
                    // Count only losses with IF actually waiting; an IF win clears it.
                    if (if_req_i) begin
                        if (!grant_mem)
                            wait_nxt = '0;
                        else if (wait_cnt != WAIT_MAX)
                            wait_nxt = wait_cnt + WCW'(1);
                    end
                end
            end
            BUSY: begin
                if (lat_cnt == '0)
                    state_nxt = IDLE;
                else
                    lat_nxt = lat_cnt - LCW'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sel_o       = 1'b0;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        if_gnt_o    = 1'b0;
        mem_gnt_o   = 1'b0;
        if_done_o   = 1'b0;
        mem_done_o  = 1'b0;
        busy_o      = (state == BUSY);
        dbg_state_o = state;
        if (state == BUSY) begin
            sel_o      = owner;
            mem_en_o   = 1'b1;
            mem_we_o   = owner && we_lat;
            if_gnt_o   = !owner;
            mem_gnt_o  = owner;
            if_done_o  = !owner && (lat_cnt == '0);
            mem_done_o = owner && (lat_cnt == '0);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: four instances cover LAT=2, LAT=1 with and without
// anti-starvation, and LAT=3; outputs are sampled 1ns after each rising edge.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rst_n, if_req, mem_req, mem_we;
    logic [3:0] sel, mem_en, mem_we_q, if_gnt, mem_gnt, if_done, mem_done, busy, dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [1:0] exp_q[$];

    mem_port_arbiter #(.LAT(2), .MAX_WAIT(4)) u0 (
        .clk_i(clk), .rst_i(rst_n[0]), .if_req_i(if_req[0]), .mem_req_i(mem_req[0]),
        .mem_we_i(mem_we[0]), .sel_o(sel[0]), .mem_en_o(mem_en[0]), .mem_we_o(mem_we_q[0]),
        .if_gnt_o(if_gnt[0]), .mem_gnt_o(mem_gnt[0]), .if_done_o(if_done[0]),
        .mem_done_o(mem_done[0]), .busy_o(busy[0]), .dbg_state_o(dbg_state[0]));

    mem_port_arbiter #(.LAT(1), .MAX_WAIT(4)) u1 (
        .clk_i(clk), .rst_i(rst_n[1]), .if_req_i(if_req[1]), .mem_req_i(mem_req[1]),
        .mem_we_i(mem_we[1]), .sel_o(sel[1]), .mem_en_o(mem_en[1]), .mem_we_o(mem_we_q[1]),
        .if_gnt_o(if_gnt[1]), .mem_gnt_o(mem_gnt[1]), .if_done_o(if_done[1]),
        .mem_done_o(mem_done[1]), .busy_o(busy[1]), .dbg_state_o(dbg_state[1]));

    mem_port_arbiter #(.LAT(1), .MAX_WAIT(0)) u2 (
        .clk_i(clk), .rst_i(rst_n[2]), .if_req_i(if_req[2]), .mem_req_i(mem_req[2]),
        .mem_we_i(mem_we[2]), .sel_o(sel[2]), .mem_en_o(mem_en[2]), .mem_we_o(mem_we_q[2]),
        .if_gnt_o(if_gnt[2]), .mem_gnt_o(mem_gnt[2]), .if_done_o(if_done[2]),
        .mem_done_o(mem_done[2]), .busy_o(busy[2]), .dbg_state_o(dbg_state[2]));

    mem_port_arbiter #(.LAT(3), .MAX_WAIT(4)) u3 (
        .clk_i(clk), .rst_i(rst_n[3]), .if_req_i(if_req[3]), .mem_req_i(mem_req[3]),
        .mem_we_i(mem_we[3]), .sel_o(sel[3]), .mem_en_o(mem_en[3]), .mem_we_o(mem_we_q[3]),
        .if_gnt_o(if_gnt[3]), .mem_gnt_o(mem_gnt[3]), .if_done_o(if_done[3]),
        .mem_done_o(mem_done[3]), .busy_o(busy[3]), .dbg_state_o(dbg_state[3]));

    // Output bundle: {sel, mem_en, mem_we, if_gnt, mem_gnt, if_done, mem_done, busy}
    function automatic logic [7:0] outs(input int k);
        return {sel[k], mem_en[k], mem_we_q[k], if_gnt[k], mem_gnt[k], if_done[k], mem_done[k], busy[k]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 4'h0; if_req = 4'hF; mem_req = 4'hF; mem_we = 4'hF;
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (outs(k) !== 8'h00 || dbg_state[k] !== 1'b0)
                $display("FAIL reset_outs inst=%0d got=%b exp=%b", k, outs(k), 8'h00);
            else n_pass++;
        end
        if_req = 4'h0; mem_req = 4'h0; mem_we = 4'h0; rst_n = 4'hF;
        tick();
    endtask

    task automatic test_if_read();
        logic [7:0] exp_seq[3];
        exp_seq[0] = 8'b0101_0001;
        exp_seq[1] = 8'b0101_0101;
        exp_seq[2] = 8'b0000_0000;
        if_req[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (outs(0) !== exp_seq[c])
                $display("FAIL if_read cycle=%0d got=%b exp=%b", c + 1, outs(0), exp_seq[c]);
            else n_pass++;
            if (if_done[0]) if_req[0] = 1'b0;
        end
        if_req[0] = 1'b0;
    endtask

    task automatic test_mem_write();
        logic [7:0] exp_seq[3];
        exp_seq[0] = 8'b1110_1001;
        exp_seq[1] = 8'b1110_1011;
        exp_seq[2] = 8'b0000_0000;
        mem_req[0] = 1'b1; mem_we[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (outs(0) !== exp_seq[c])
                $display("FAIL mem_write cycle=%0d got=%b exp=%b", c + 1, outs(0), exp_seq[c]);
            else n_pass++;
            mem_we[0] = 1'b0;  // late change must not affect the latched write enable
            if (mem_done[0]) mem_req[0] = 1'b0;
        end
        mem_req[0] = 1'b0;
    endtask

    task automatic test_we_without_req();
        mem_we[0] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (outs(0) !== 8'h00)
                $display("FAIL we_without_req cycle=%0d got=%b exp=%b", c, outs(0), 8'h00);
            else n_pass++;
        end
        mem_we[0] = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_seq[6];
        exp_seq[0] = 8'b0101_0001;
        exp_seq[1] = 8'b0101_0101;
        exp_seq[2] = 8'b0000_0000;
        exp_seq[3] = 8'b0101_0001;
        exp_seq[4] = 8'b0101_0101;
        exp_seq[5] = 8'b0000_0000;
        if_req[0] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_checks++;
            if (outs(0) !== exp_seq[c])
                $display("FAIL back_to_back cycle=%0d got=%b exp=%b", c + 1, outs(0), exp_seq[c]);
            else n_pass++;
            if (c == 4) if_req[0] = 1'b0;
        end
    endtask

    task automatic test_starvation();
        int wmodel = 0;
        for (int i = 0; i < 10; i++)
            exp_q.push_back((i % 5 == 4) ? 2'b10 : 2'b01);
        if_req[1] = 1'b1; mem_req[1] = 1'b1; mem_we[1] = 1'($urandom_range(0, 1));
        for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
            tick();
            if (if_done[1] || mem_done[1]) begin
                logic [1:0] exp_d;
                exp_d = exp_q.pop_front();
                n_checks++;
                if ({if_done[1], mem_done[1]} !== exp_d)
                    $display("FAIL starve_order got=%b exp=%b", {if_done[1], mem_done[1]}, exp_d);
                else n_pass++;
                wmodel = (exp_d == 2'b10) ? 0 : ((wmodel < 4) ? wmodel + 1 : 4);
                n_checks++;
                if (u1.wait_cnt !== 3'(wmodel))
                    $display("FAIL starve_wait_cnt got=%0d exp=%0d", u1.wait_cnt, wmodel);
                else n_pass++;
            end
        end
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL starve_timeout got=%0d pending exp=0", exp_q.size());
        else n_pass++;
        exp_q.delete();
        if_req[1] = 1'b0; mem_req[1] = 1'b0; mem_we[1] = 1'b0;
        tick(); tick();
    endtask

    task automatic test_mem_priority();
        for (int i = 0; i < 10; i++) exp_q.push_back(2'b01);
        if_req[2] = 1'b1; mem_req[2] = 1'b1;
        for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
            tick();
            if (if_done[2] || mem_done[2]) begin
                logic [1:0] exp_d;
                exp_d = exp_q.pop_front();
                n_checks++;
                if ({if_done[2], mem_done[2]} !== exp_d)
                    $display("FAIL prio_order got=%b exp=%b", {if_done[2], mem_done[2]}, exp_d);
                else n_pass++;
            end
        end
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL prio_timeout got=%0d pending exp=0", exp_q.size());
        else n_pass++;
        exp_q.delete();
        if_req[2] = 1'b0; mem_req[2] = 1'b0;
        tick(); tick();
    endtask

    task automatic test_drop_mid();
        logic [7:0] exp_seq[5];
        exp_seq[0] = 8'b1100_1001;
        exp_seq[1] = 8'b1100_1001;
        exp_seq[2] = 8'b1100_1011;
        exp_seq[3] = 8'b0000_0000;
        exp_seq[4] = 8'b0000_0000;
        mem_req[3] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (outs(3) !== exp_seq[c])
                $display("FAIL drop_mid cycle=%0d got=%b exp=%b", c + 1, outs(3), exp_seq[c]);
            else n_pass++;
            if (c == 0) if_req[3] = 1'b1;
            if (c == 1) begin if_req[3] = 1'b0; mem_req[3] = 1'b0; end
        end
    endtask

    task automatic test_reset_mid();
        int seen_done = 0;
        mem_req[3] = 1'b1;
        tick();
        tick();
        n_checks++;
        if (outs(3) !== 8'b1100_1001)
            $display("FAIL reset_mid_busy got=%b exp=%b", outs(3), 8'b1100_1001);
        else n_pass++;
        rst_n[3] = 1'b0; mem_req[3] = 1'b0;
        tick();
        n_checks++;
        if (outs(3) !== 8'h00)
            $display("FAIL reset_mid_outs got=%b exp=%b", outs(3), 8'h00);
        else n_pass++;
        rst_n[3] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (if_done[3] || mem_done[3] || busy[3]) seen_done++;
        end
        n_checks++;
        if (seen_done != 0)
            $display("FAIL reset_mid_no_done got=%0d exp=0", seen_done);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_mem_write();
        test_we_without_req();
        test_back_to_back();
        test_starvation();
        test_mem_priority();
        test_drop_mid();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
